// File: rtl/regset_pkg.sv
// Shared types and widths for the register-set write-back path.
package regset_pkg;

    localparam int REG_AW = 6;
    localparam int XLEN   = 32;

    // One outstanding load: its destination and whether a younger write
    // has already overwritten that destination.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              kill;
    } wb_tag_t;

    // Which source owns the register-set write port in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MARK,
        WB_LOAD
    } wb_src_t;

endpackage

// File: rtl/wb_tag_fifo.sv
// In-order FIFO of outstanding load destinations with a broadcast kill port
// that flags entries made stale by a later write to the same register.
import regset_pkg::*;

module wb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [REG_AW-1:0]        push_rd,
    input  logic                     pop,
    input  logic                     kill_en,
    input  logic [REG_AW-1:0]        kill_rd,
    output logic [REG_AW-1:0]        head_rd,
    output logic                     head_kill,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wb_tag_t              entries [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [AW:0]          cnt;
    logic                 push_ok;
    logic                 pop_ok;

    assign full      = (cnt == (AW+1)'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_rd   = entries[rd_ptr].rd;
    assign head_kill = entries[rd_ptr].kill;

    // Kill broadcast first, then pop and push; the entry being popped is
    // cleared outright so a same-cycle kill match on it has no effect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && valid[i] && (entries[i].rd == kill_rd) &&
                    !(pop_ok && (rd_ptr == AW'(i)))) begin
                    entries[i].kill <= 1'b1;
                end
            end
            if (pop_ok) begin
                valid[rd_ptr]        <= 1'b0;
                entries[rd_ptr].kill <= 1'b0;
                rd_ptr               <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                entries[wr_ptr].rd   <= push_rd;
                entries[wr_ptr].kill <= 1'b0;
                valid[wr_ptr]        <= 1'b1;
                wr_ptr               <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/regset_writeback.sv
// Merges ALU results, load-issue grubby marks and in-order load responses
// onto the register set's single registered write port.
import regset_pkg::*;

module regset_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     alu_valid,
    input  logic [REG_AW-1:0]        alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_issue_valid,
    output logic                     ld_issue_ready,
    input  logic [REG_AW-1:0]        ld_issue_rd,
    input  logic                     ld_resp_valid,
    output logic                     ld_resp_ready,
    input  logic [XLEN-1:0]          ld_resp_data,
    output logic                     we,
    output logic [REG_AW-1:0]        wa,
    output logic [XLEN-1:0]          wd,
    output logic                     wg,
    output logic [$clog2(DEPTH):0]   pending
);

    logic                 full;
    logic                 empty;
    logic [REG_AW-1:0]    head_rd;
    logic                 head_kill;
    logic                 issue_fire;
    logic                 kill_en;
    logic [REG_AW-1:0]    kill_rd;
    wb_src_t              sel;
    logic                 nxt_we;
    logic [REG_AW-1:0]    nxt_wa;
    logic [XLEN-1:0]      nxt_wd;
    logic                 nxt_wg;

    assign ld_issue_ready = !full;
    assign issue_fire     = ld_issue_valid && !full;
    assign ld_resp_ready  = ld_resp_valid && !empty && !alu_valid && !ld_issue_valid;

    // Any ALU write or accepted issue supersedes older loads to the same rd.
    assign kill_en = alu_valid || issue_fire;
    assign kill_rd = alu_valid ? alu_rd : ld_issue_rd;

    wb_tag_fifo #(
        .DEPTH     (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (issue_fire),
        .push_rd   (ld_issue_rd),
        .pop       (ld_resp_ready),
        .kill_en   (kill_en),
        .kill_rd   (kill_rd),
        .head_rd   (head_rd),
        .head_kill (head_kill),
        .full      (full),
        .empty     (empty),
        .count     (pending)
    );

    // Fixed-priority pick of the source that owns the write port.
    always_comb begin
        sel = WB_NONE;
        if (alu_valid) begin
            sel = WB_ALU;
        end else if (issue_fire) begin
            sel = WB_MARK;
        end else if (ld_resp_ready) begin
            sel = WB_LOAD;
        end
    end

    // Build the write for the selected source; x0 and killed loads suppress we.
    always_comb begin
        nxt_we = 1'b0;
        nxt_wa = '0;
        nxt_wd = '0;
        nxt_wg = 1'b0;
        case (sel)
            WB_ALU: begin
                nxt_we = (alu_rd != '0);
                nxt_wa = alu_rd;
                nxt_wd = alu_data;
            end
            WB_MARK: begin
                nxt_we = (ld_issue_rd != '0);
                nxt_wa = ld_issue_rd;
                nxt_wg = 1'b1;
            end
            WB_LOAD: begin
                nxt_we = (head_rd != '0) && !head_kill;
                nxt_wa = head_rd;
                nxt_wd = ld_resp_data;
            end
            default: begin
                nxt_we = 1'b0;
            end
        endcase
    end

    // Register the write port so the register set sees clean timing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
            wg <= 1'b0;
        end else begin
            we <= nxt_we;
            wa <= nxt_wa;
            wd <= nxt_wd;
            wg <= nxt_wg;
        end
    end

endmodule

// File: tb/tb_regset_writeback.sv
// Randomised and directed bench for regset_writeback against a queue-based
// model of outstanding loads.
module tb_regset_writeback;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rstn;
    logic        alu_valid;
    logic [5:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue_valid;
    logic        ld_issue_ready;
    logic [5:0]  ld_issue_rd;
    logic        ld_resp_valid;
    logic        ld_resp_ready;
    logic [31:0] ld_resp_data;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        wg;
    logic [2:0]  pending;

    int total;
    int bad;

    int q_rd[$];
    bit q_kill[$];

    regset_writeback #(
        .DEPTH          (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_ready (ld_issue_ready),
        .ld_issue_rd    (ld_issue_rd),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_ready  (ld_resp_ready),
        .ld_resp_data   (ld_resp_data),
        .we             (we),
        .wa             (wa),
        .wd             (wd),
        .wg             (wg),
        .pending        (pending)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check combinational/status outputs mid-cycle,
    // advance the model, then check the registered write after the edge.
    task automatic applyStimulus(input bit av, input int ard, input logic [31:0] ad,
                                 input bit iv, input int ird,
                                 input bit rv, input logic [31:0] rdata);
        bit          exp_ir;
        bit          exp_rr;
        bit          fire;
        bit          exp_we;
        bit          exp_wg;
        int          exp_wa;
        logic [31:0] exp_wd;
        int          krd;
        int          dummy_rd;
        bit          dummy_kill;
        alu_valid      = av;
        alu_rd         = 6'(ard);
        alu_data       = ad;
        ld_issue_valid = iv;
        ld_issue_rd    = 6'(ird);
        ld_resp_valid  = rv;
        ld_resp_data   = rdata;
        #4;
        exp_ir = (q_rd.size() < DEPTH);
        exp_rr = rv && (q_rd.size() > 0) && !av && !iv;
        checkOutput("ld_issue_ready", {31'b0, ld_issue_ready}, {31'b0, exp_ir});
        checkOutput("ld_resp_ready", {31'b0, ld_resp_ready}, {31'b0, exp_rr});
        checkOutput("pending", {29'b0, pending}, q_rd.size());
        fire   = iv && exp_ir;
        exp_we = 1'b0;
        exp_wg = 1'b0;
        exp_wa = 0;
        exp_wd = '0;
        if (av) begin
            exp_we = (ard != 0);
            exp_wa = ard;
            exp_wd = ad;
        end else if (fire) begin
            exp_we = (ird != 0);
            exp_wa = ird;
            exp_wg = 1'b1;
        end else if (exp_rr) begin
            exp_we = (q_rd[0] != 0) && !q_kill[0];
            exp_wa = q_rd[0];
            exp_wd = rdata;
        end
        if (av || fire) begin
            krd = av ? ard : ird;
            foreach (q_rd[i]) begin
                if (q_rd[i] == krd) q_kill[i] = 1'b1;
            end
        end
        if (exp_rr) begin
            dummy_rd   = q_rd.pop_front();
            dummy_kill = q_kill.pop_front();
        end
        if (fire) begin
            q_rd.push_back(ird);
            q_kill.push_back(1'b0);
        end
        @(posedge clk);
        #1;
        checkOutput("we", {31'b0, we}, {31'b0, exp_we});
        if (exp_we) begin
            checkOutput("wa", {26'b0, wa}, exp_wa);
            checkOutput("wd", wd, exp_wd);
            checkOutput("wg", {31'b0, wg}, {31'b0, exp_wg});
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    // Asynchronous reset in the middle of a cycle; everything must clear.
    task automatic doReset();
        alu_valid      = 1'b0;
        ld_issue_valid = 1'b0;
        ld_resp_valid  = 1'b0;
        rstn           = 1'b0;
        #1;
        checkOutput("rst_we", {31'b0, we}, 32'h0);
        checkOutput("rst_wa", {26'b0, wa}, 32'h0);
        checkOutput("rst_wd", wd, 32'h0);
        checkOutput("rst_wg", {31'b0, wg}, 32'h0);
        checkOutput("rst_pending", {29'b0, pending}, 32'h0);
        checkOutput("rst_issue_ready", {31'b0, ld_issue_ready}, 32'h1);
        q_rd.delete();
        q_kill.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Directed test-plan scenarios followed by a randomised soak.
    initial begin
        total          = 0;
        bad            = 0;
        rstn           = 1'b0;
        alu_valid      = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
        ld_resp_valid  = 1'b0;
        ld_resp_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_we", {31'b0, we}, 32'h0);
        checkOutput("init_pending", {29'b0, pending}, 32'h0);
        checkOutput("init_issue_ready", {31'b0, ld_issue_ready}, 32'h1);
        rstn = 1'b1;
        idleCycle();

        $display("[TB] single load");
        applyStimulus(0, 0, 32'h0, 1, 5, 0, 32'h0);
        checkOutput("single_mark_wa", {26'b0, wa}, 32'd5);
        checkOutput("single_mark_wg", {31'b0, wg}, 32'h1);
        idleCycle();
        idleCycle();
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'hDEADBEEF);
        checkOutput("single_wd", wd, 32'hDEADBEEF);
        checkOutput("single_pending", {29'b0, pending}, 32'h0);

        $display("[TB] fill and drain");
        for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 32'h0, 1, i, 0, 32'h0);
        checkOutput("fill_pending", {29'b0, pending}, 32'd4);
        checkOutput("fill_ready", {31'b0, ld_issue_ready}, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 5, 0, 32'h0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h100 + i);
        checkOutput("drain_ready", {31'b0, ld_issue_ready}, 32'h1);

        $display("[TB] collision");
        applyStimulus(0, 0, 32'h0, 1, 12, 0, 32'h0);
        applyStimulus(1, 7, 32'h11, 0, 0, 1, 32'h22);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h22);

        $display("[TB] waw kill");
        applyStimulus(0, 0, 32'h0, 1, 9, 0, 32'h0);
        applyStimulus(1, 9, 32'h55, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h99);
        checkOutput("waw_we", {31'b0, we}, 32'h0);

        $display("[TB] x0 and reset");
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h77);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 1, 20 + i, 0, 32'h0);
        checkOutput("pre_reset_pending", {29'b0, pending}, 32'd3);
        doReset();
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h33);

        $display("[TB] random");
        for (int n = 0; n < 600; n++) begin
            int  kind;
            bit  av;
            bit  iv;
            kind = $urandom_range(0, 9);
            av   = (kind <= 2);
            iv   = (kind == 3) || (kind == 4);
            if (n == 300) doReset();
            applyStimulus(av, $urandom_range(0, 7), $urandom,
                          iv, $urandom_range(0, 7),
                          ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
